// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multicycle RISC-V control unit (Moore FSM plus ALU decoder)
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset to FETCH
//   op, funct3, funct7b5    instruction fields from the external instruction register
//   Zero                    ALU zero flag, used for branch resolution in BEQ
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite
//                           datapath selects and enables, all combinational
// Optional feature macro: RISCV_MC_CONTROLLER_BNE_EN (bne, funct3=001, via the BEQ state)

module riscv_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       branch_take;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    // Illegal opcode: drop back to fetch with no writes
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU decoder; sub only for R-type (op[5]=1) with bit 30 set, never for addi
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

`ifdef RISCV_MC_CONTROLLER_BNE_EN
    assign branch_take = (funct3 == 3'b001) ? ~Zero : Zero;
`else
    assign branch_take = Zero;
`endif

    assign PCWrite = pc_update | (branch & branch_take);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - self-checking bench for riscv_mc_controller

module tb_riscv_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;

    riscv_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite}
    logic [15:0] dut_word;
    assign dut_word = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                       ALUSrcB, ALUControl, ImmSrc, RegWrite};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [2:0] alu2;
        logic       pcw2;
    } vec_t;

    vec_t        tbl[16];
    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_next(input int st, input logic [6:0] o);
        case (st)
            0: return 1;
            1: begin
                if (o == 7'b0000011 || o == 7'b0100011) return 2;
                if (o == 7'b0110011) return 6;
                if (o == 7'b0010011) return 8;
                if (o == 7'b1101111) return 9;
                if (o == 7'b1100011) return 10;
                return 0;
            end
            2: return (o == 7'b0000011) ? 3 : 5;
            3: return 4;
            6, 8, 9: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] m_out(input int st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
        logic       pcw, adr, mw, irw, rw, pcu, br, tk;
        logic [1:0] rs, sa, sb, aop, imm;
        logic [2:0] ac;
        {pcw, adr, mw, irw, rw, pcu, br} = '0;
        {rs, sa, sb, aop} = '0;
        case (st)
            0: begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            1: begin sa = 2'b01; sb = 2'b01; end
            2: begin sa = 2'b10; sb = 2'b01; end
            3: adr = 1;
            4: begin rs = 2'b01; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: begin sa = 2'b10; aop = 2'b10; end
            7: rw = 1;
            8: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            9: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            10: begin sa = 2'b10; aop = 2'b01; br = 1; end
            default: ;
        endcase
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            if (f3 == 3'b000) ac = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
            else ac = 3'b000;
        end else ac = 3'b000;
`ifdef RISCV_MC_CONTROLLER_BNE_EN
        tk = (f3 == 3'b001) ? !z : z;
`else
        tk = z;
`endif
        pcw = pcu | (br & tk);
        if (o == 7'b0100011) imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        else imm = 2'b00;
        return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw};
    endfunction

    // Scoreboard step: push the model's expectation, pop it against the DUT
    task automatic sb_check(input string name, input int st, input int c);
        logic [15:0] e;
        exp_q.push_back(m_out(st, op, funct3, funct7b5, Zero));
        e = exp_q.pop_front();
        chk($sformatf("%s cyc%0d outputs", name, c), dut_word, e);
    endtask

    // Entered just after a negedge while the DUT sits in FETCH
    task automatic run_instr(input int i);
        int st;
        int lat;
        op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; Zero = tbl[i].z;
        #1;
        st = 0;
        sb_check(tbl[i].name, st, 0);
        st = m_next(st, op);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            sb_check(tbl[i].name, st, c);
            if (c == 2) begin
                chk({tbl[i].name, " ALUControl cyc2"}, {13'd0, ALUControl}, {13'd0, tbl[i].alu2});
                chk({tbl[i].name, " PCWrite cyc2"}, {15'd0, PCWrite}, {15'd0, tbl[i].pcw2});
            end
            st = m_next(st, op);
            if (IRWrite) begin
                lat = c;
                break;
            end
        end
        chk({tbl[i].name, " latency"}, lat[15:0], tbl[i].lat[15:0]);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        tbl[0]  = '{"lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0};
        tbl[1]  = '{"sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0};
        tbl[2]  = '{"sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0};
        tbl[3]  = '{"add",     7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0};
        tbl[4]  = '{"and",     7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0};
        tbl[5]  = '{"or",      7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0};
        tbl[6]  = '{"slt",     7'b0110011, 3'b010, 1'b0, 1'b1, 4, 3'b101, 1'b0};
        tbl[7]  = '{"addi_b30",7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0};
        tbl[8]  = '{"slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0};
        tbl[9]  = '{"ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0};
        tbl[10] = '{"r_f3_001",7'b0110011, 3'b001, 1'b1, 1'b0, 4, 3'b000, 1'b0};
        tbl[11] = '{"beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1};
        tbl[12] = '{"beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0};
        tbl[13] = '{"jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1};
        tbl[14] = '{"illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 2, 3'b000, 1'b1};
`ifdef RISCV_MC_CONTROLLER_BNE_EN
        tbl[15] = '{"bne_z1",  7'b1100011, 3'b001, 1'b0, 1'b1, 3, 3'b001, 1'b0};
`else
        tbl[15] = '{"bne_z1",  7'b1100011, 3'b001, 1'b0, 1'b1, 3, 3'b001, 1'b1};
`endif

        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset IRWrite", {15'd0, IRWrite}, 16'd1);
        chk("reset PCWrite", {15'd0, PCWrite}, 16'd1);
        chk("reset MemWrite", {15'd0, MemWrite}, 16'd0);
        chk("reset RegWrite", {15'd0, RegWrite}, 16'd0);
        chk("reset ALUSrcB", {14'd0, ALUSrcB}, 16'd2);
        chk("reset ResultSrc", {14'd0, ResultSrc}, 16'd2);

        for (int i = 0; i < 16; i++) run_instr(i);

        // lw aborted in MEMREAD
        op = 7'b0000011; funct3 = 3'b010;
        repeat (3) @(negedge clk);
        chk("abort_lw AdrSrc in S3", {15'd0, AdrSrc}, 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_lw AdrSrc during reset cycle", {15'd0, AdrSrc}, 16'd1);
        @(negedge clk);
        chk("abort_lw IRWrite after reset", {15'd0, IRWrite}, 16'd1);
        chk("abort_lw AdrSrc after reset", {15'd0, AdrSrc}, 16'd0);
        @(negedge clk);
        chk("abort_lw held in fetch", {15'd0, IRWrite}, 16'd1);
        reset = 1'b0;

        // sw aborted in MEMWRITE
        op = 7'b0100011;
        repeat (3) @(negedge clk);
        chk("abort_sw MemWrite in S5", {15'd0, MemWrite}, 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_sw MemWrite during reset cycle", {15'd0, MemWrite}, 16'd1);
        @(negedge clk);
        chk("abort_sw MemWrite after reset", {15'd0, MemWrite}, 16'd0);
        chk("abort_sw IRWrite after reset", {15'd0, IRWrite}, 16'd1);
        reset = 1'b0;

        run_instr(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
